// File: rtl/cordic_pkg.sv
// Shared Q4.8 fixed-point definitions for the ray pipeline
// (generator, normalisation and intersection stages).
package cordic_pkg;

   typedef logic signed [11:0] fix_q48_t;

   localparam int       Q_FRAC  = 8;
   localparam fix_q48_t ONE_Q48 = 12'sd256;

endpackage

// File: rtl/ray_direction_generator_raster_counter.sv
// Column/row raster position for the ray generator, with end-of-row,
// last-pixel and frame-exhausted flags.
module raster_counter #(
   parameter int H_RES = 64,
   parameter int V_RES = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic advance,
   output logic end_of_row,
   output logic last_pixel,
   output logic exhausted
);

   localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;

   assign end_of_row = (col == COL_W'(H_RES - 1));
   assign last_pixel = end_of_row && (row == ROW_W'(V_RES - 1));

   // The row counter wraps after the final pixel, so "exhausted" records
   // that the whole frame has been issued.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col       <= '0;
         row       <= '0;
         exhausted <= 1'b0;
      end else if (clear) begin
         col       <= '0;
         row       <= '0;
         exhausted <= 1'b0;
      end else if (advance) begin
         if (end_of_row) begin
            col <= '0;
            row <= last_pixel ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
         if (last_pixel) begin
            exhausted <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ray_direction_generator.sv
// Raster-scan primary-ray generator: one un-normalised Q4.8 camera-space
// direction per unstalled cycle, tagged with a sequential ID.
module ray_direction_generator
   import cordic_pkg::*;
#(
   parameter int       H_RES    = 64,
   parameter int       V_RES    = 64,
   parameter fix_q48_t PIX_STEP = 12'sd8,
   parameter fix_q48_t FOCAL    = ONE_Q48,
   parameter int       ID_WIDTH = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                stall,
   output fix_q48_t            x_out,
   output fix_q48_t            y_out,
   output fix_q48_t            z_out,
   output logic [ID_WIDTH-1:0] out_id,
   output logic                out_valid,
   output logic                busy,
   output logic                done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int       X_SPAN  = (H_RES / 2) * int'(PIX_STEP);
   localparam int       Y_SPAN  = (V_RES / 2) * int'(PIX_STEP);
   localparam fix_q48_t X_START = fix_q48_t'(-X_SPAN);
   localparam fix_q48_t Y_START = fix_q48_t'(Y_SPAN);

   if (X_SPAN > 2047 || Y_SPAN > 2047) begin : g_span_check
      $error("ray_direction_generator: half-frame span exceeds Q4.8 range");
   end
   if (H_RES < 2 || V_RES < 2 || (H_RES % 2) != 0 || (V_RES % 2) != 0) begin : g_res_check
      $error("ray_direction_generator: H_RES and V_RES must be even and >= 2");
   end

   logic [1:0]          state;
   fix_q48_t            x_acc;
   fix_q48_t            y_acc;
   logic [ID_WIDTH-1:0] id_ctr;
   logic                counter_clear;
   logic                advance;
   logic                end_of_row;
   logic                last_pixel;
   logic                exhausted;

   assign counter_clear = (state == IDLE) && start;
   assign advance       = (state == RUN) && !stall && !exhausted;

   raster_counter #(
      .H_RES(H_RES),
      .V_RES(V_RES)
   ) u_raster (
      .clock     (clock),
      .reset     (reset),
      .clear     (counter_clear),
      .advance   (advance),
      .end_of_row(end_of_row),
      .last_pixel(last_pixel),
      .exhausted (exhausted)
   );

   // Stalls only insert bubbles; the data outputs keep the last issued ray.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         x_acc     <= '0;
         y_acc     <= '0;
         id_ctr    <= '0;
         x_out     <= '0;
         y_out     <= '0;
         z_out     <= '0;
         out_id    <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               done      <= 1'b0;
               if (start) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  x_acc  <= X_START;
                  y_acc  <= Y_START;
                  id_ctr <= '0;
               end
            end
            RUN: begin
               if (stall) begin
                  out_valid <= 1'b0;
               end else if (exhausted) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end else begin
                  x_out     <= x_acc;
                  y_out     <= y_acc;
                  z_out     <= FOCAL;
                  out_id    <= id_ctr;
                  out_valid <= 1'b1;
                  id_ctr    <= id_ctr + ID_WIDTH'(1);
                  if (end_of_row) begin
                     x_acc <= X_START;
                     y_acc <= y_acc - PIX_STEP;
                  end else begin
                     x_acc <= x_acc + PIX_STEP;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ray_direction_generator.md
Name: ray_direction_generator

Overview:
- Raster-scan primary-ray generator for the ray pipeline; sits directly upstream of the CORDIC vector-normalisation stage.
- Per frame, issues one un-normalised camera-space direction (x, y, z) per cycle in Q4.8, tagged with a sequential ID.
- The normalisation stage has fixed latency and no backpressure, so every asserted out_valid is a consumed ray.
- Pacing is by inserting bubbles via stall, never by holding data.

Parameters:
- H_RES, 64, pixels per row (even, ≥2)
- V_RES, 64, rows per frame (even, ≥2)
- PIX_STEP, 12'sd8, Q4.8 angular step per pixel (1/32)
- FOCAL, 12'sd256, Q4.8 constant z component (1.0)
- ID_WIDTH, 8, width of ray ID tag

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a frame; honoured only in IDLE
- stall  in  1  when high at an edge, no ray is issued for the following cycle
- x_out  out  12 signed  Q4.8 horizontal direction component
- y_out  out  12 signed  Q4.8 vertical direction component
- z_out  out  12 signed  Q4.8 depth component
- out_id  out  ID_WIDTH  ray tag, valid with out_valid
- out_valid  out  1  ray presented this cycle; it is consumed unconditionally
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; all counters and accumulators 0.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE + start=1 at an edge:
  - go to RUN; out_valid stays 0.
  - col=0, row=0, id_ctr=0.
  - x_acc = -(H_RES/2)*PIX_STEP; y_acc = +(V_RES/2)*PIX_STEP.
- RUN, edge with stall=1: out_valid<=0; data outputs, counters and accumulators hold.
- RUN, edge with stall=0 and pixels remaining:
  - issue ray: x_out<=x_acc, y_out<=y_acc, z_out<=FOCAL, out_id<=id_ctr, out_valid<=1.
  - advance: id_ctr+1 (wraps modulo 2^ID_WIDTH).
  - if col==H_RES-1: col<=0, x_acc reloaded to its start value, row+1, y_acc-=PIX_STEP.
  - else: col+1, x_acc+=PIX_STEP.
- RUN, edge with stall=0 and all H_RES*V_RES rays issued: out_valid<=0, done<=1, state DONE.
- DONE: next edge done<=0, go to IDLE. A start seen in DONE is ignored.
- Latency and rate:
  - first ray visible 2 cycles after the start edge (with stall=0).
  - unstalled frame: out_valid high for exactly H_RES*V_RES consecutive cycles.
  - done rises the cycle after the last valid.
- start while in RUN or DONE: ignored. No restart, and no effect on counters.
- stall in IDLE/DONE: no effect.
- Between valid rays, x/y/z/out_id hold their last issued values. The downstream ignores them because it samples only with out_valid.
- Arithmetic:
  - x_acc/y_acc are 12-bit signed adders only; no multipliers.
  - Elaboration assertion: (H_RES/2)*PIX_STEP and (V_RES/2)*PIX_STEP each ≤ 2047.
  - col/row counters are $clog2(H_RES) and $clog2(V_RES) bits.
- Reset mid-frame: immediate return to IDLE with all outputs 0. Any rays already in flight downstream are the downstream's concern.

Decomposition:
- Shared fixed-point package cordic_pkg:
  - typedef fix_q48_t (logic signed [11:0]);
  - Q_FRAC=8;
  - ONE_Q48=12'sd256.
  - Reused by the normalisation and intersection stages.
- FSM state enum: local to the module.
- One natural sub-module, raster_counter:
  - col/row counters with end-of-row and end-of-frame flags;
  - accumulators and FSM stay in the top.

Test Plan:
- Defaults, reset then start pulse, stall=0 -> ray0 two cycles later: x=-256, y=256, z=256, id=0; next cycle x=-248, y=256, id=1.
- Full unstalled frame -> exactly 4096 valids, consecutive:
  - ray 63: x=248, y=256;
  - ray 64: x=-256, y=248, id=64;
  - ray 4095: x=248, y=-248, id=255.
  - done high exactly one cycle after the last valid; busy low afterwards.
- stall=1 for 3 edges after ray 10 -> 3 bubble cycles with out_valid=0 and outputs held; ray 11 next: x=-168, id=11, with no ray skipped or duplicated.
- start asserted again mid-frame and in DONE -> ignored; frame completes with 4096 rays; a later start in IDLE restarts at id=0.
- reset asserted asynchronously mid-frame (between edges) -> outputs, busy and done go 0 immediately; a subsequent start yields ray0 values again.
- H_RES=4, V_RES=2, PIX_STEP=64:
  - rays (x,y) = (-128,64), (-64,64), (0,64), (64,64), (-128,0), (-64,0), (0,0), (64,0);
  - done follows.
